// File: rtl/move_recorder_pkg.sv
// move_recorder_pkg: move codes, recorder states and the opposite() helper
package move_recorder_pkg;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, REC, DONE} state_t;
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction
endpackage

// File: rtl/move_cancel_chk.sv
// move_cancel_chk: flags mv_dir as undoing last_dir when a stored move exists
module move_cancel_chk
  import move_recorder_pkg::*;
(
  input  logic [1:0] mv_dir,
  input  logic [1:0] last_dir,
  input  logic       has_last,
  output logic       cancel
);
  assign cancel = has_last && (mv_dir == opposite(dir_t'(last_dir)));
endmodule

// File: rtl/move_recorder.sv
// move_recorder: packs solver moves into ord/cnt with comp/ovf flags; MOVE_CANCEL_EN pops a move undone by its opposite
module move_recorder
  import move_recorder_pkg::*;
#(
  parameter int MAX_MOVES = 32,
  parameter int CNT_W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mv_valid,
  input  logic [1:0]             mv_dir,
  output logic                   mv_ready,
  input  logic                   done_in,
  output logic                   comp,
  output logic [CNT_W-1:0]       cnt,
  output logic [2*MAX_MOVES-1:0] ord,
  output logic                   ovf
);
  localparam int IW = $clog2(MAX_MOVES);
  state_t        state;
  logic          full;
  logic          cancel;
  logic [IW-1:0] top_i;
  logic [IW-1:0] last_i;
  assign full   = cnt == CNT_W'(MAX_MOVES);
  assign top_i  = IW'(cnt);
  assign last_i = IW'(cnt - 1'b1);
`ifdef MOVE_CANCEL_EN
  logic [1:0] last_dir;
  assign last_dir = ord[{last_i, 1'b0} +: 2];
  move_cancel_chk u_chk (
    .mv_dir   (mv_dir),
    .last_dir (last_dir),
    .has_last (cnt != '0),
    .cancel   (cancel)
  );
`else
  assign cancel = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      mv_ready <= 1'b0;
      comp     <= 1'b0;
      cnt      <= '0;
      ord      <= '0;
      ovf      <= 1'b0;
    end else if (start) begin
      state    <= REC;
      mv_ready <= 1'b1;
      comp     <= 1'b0;
      cnt      <= '0;
      ord      <= '0;
      ovf      <= 1'b0;
    end else if (state == REC) begin
      if (mv_valid) begin
        if (cancel) begin
          ord[{last_i, 1'b0} +: 2] <= 2'b00;
          cnt                      <= cnt - 1'b1;
        end else if (full) begin
          ovf <= 1'b1;
        end else begin
          ord[{top_i, 1'b0} +: 2] <= mv_dir;
          cnt                     <= cnt + 1'b1;
        end
      end
      if (done_in) begin
        state    <= DONE;
        mv_ready <= 1'b0;
        comp     <= 1'b1;
      end
    end
endmodule

// File: tb/tb_move_recorder.sv
// tb_move_recorder: scoreboard bench for move_recorder with directed vectors
module tb_move_recorder;
  import move_recorder_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mv_valid = 1'b0;
  logic [1:0]  mv_dir = 2'b00;
  logic        done_in = 1'b0;
  logic        mv_ready;
  logic        comp;
  logic [63:0] cnt;
  logic [63:0] ord;
  logic        ovf;
  typedef struct {
    string       name;
    logic        c;
    logic [63:0] n;
    logic [63:0] o;
    logic        v;
    logic        r;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   passed = 0;
  int   total = 0;
  move_recorder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mv_valid (mv_valid),
    .mv_dir   (mv_dir),
    .mv_ready (mv_ready),
    .done_in  (done_in),
    .comp     (comp),
    .cnt      (cnt),
    .ord      (ord),
    .ovf      (ovf)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({comp, cnt, ord, ovf, mv_ready} === {e.c, e.n, e.o, e.v, e.r})
        passed++;
      else
        $display("FAIL %s: got comp=%0b cnt=%0d ord=%h ovf=%0b rdy=%0b, expected comp=%0b cnt=%0d ord=%h ovf=%0b rdy=%0b",
                 e.name, comp, cnt, ord, ovf, mv_ready, e.c, e.n, e.o, e.v, e.r);
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string nm, input logic c, input logic [63:0] n,
                            input logic [63:0] o, input logic v, input logic r);
    q.push_back('{nm, c, n, o, v, r});
    cyc();
  endtask
  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask
  task automatic mv(input dir_t d);
    mv_valid = 1'b1;
    mv_dir   = d;
    cyc();
    mv_valid = 1'b0;
  endtask
  task automatic finish_seq();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
  endtask
  initial begin
    dir_t cyc4[4];
    cyc4 = '{UP, LEFT, DOWN, RIGHT};
    cyc();
    cyc();
    expect_out("reset", 1'b0, 64'd0, 64'h0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc();
    mv(UP);
    expect_out("idle_ignore", 1'b0, 64'd0, 64'h0, 1'b0, 1'b0);
    do_start();
    mv(UP); mv(LEFT); mv(DOWN); mv(RIGHT); mv(UP);
    expect_out("rec_cnt5", 1'b0, 64'd5, 64'hD8, 1'b0, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_out("rst_mid_rec", 1'b0, 64'd0, 64'h0, 1'b0, 1'b0);
    do_start();
    expect_out("start_clear", 1'b0, 64'd0, 64'h0, 1'b0, 1'b1);
    mv(UP); mv(LEFT); mv(LEFT);
    finish_seq();
    expect_out("three_moves", 1'b1, 64'd3, 64'h28, 1'b0, 1'b0);
    do_start();
    mv(UP); mv(RIGHT); mv(LEFT);
`ifdef MOVE_CANCEL_EN
    expect_out("cancel_pop", 1'b0, 64'd1, 64'h0, 1'b0, 1'b1);
`else
    expect_out("no_cancel", 1'b0, 64'd3, 64'h2C, 1'b0, 1'b1);
`endif
    do_start();
    for (int i = 0; i < 32; i++) mv(cyc4[i % 4]);
    expect_out("full_32", 1'b0, 64'd32, 64'hD8D8D8D8D8D8D8D8, 1'b0, 1'b1);
    mv(UP);
    expect_out("overflow", 1'b0, 64'd32, 64'hD8D8D8D8D8D8D8D8, 1'b1, 1'b1);
    mv(LEFT);
`ifdef MOVE_CANCEL_EN
    expect_out("cancel_full", 1'b0, 64'd31, 64'h18D8D8D8D8D8D8D8, 1'b1, 1'b1);
`else
    expect_out("full_drop", 1'b0, 64'd32, 64'hD8D8D8D8D8D8D8D8, 1'b1, 1'b1);
`endif
    do_start();
    mv(UP); mv(UP); mv(LEFT); mv(LEFT);
    mv_valid = 1'b1;
    mv_dir   = DOWN;
    done_in  = 1'b1;
    cyc();
    mv_valid = 1'b0;
    done_in  = 1'b0;
    expect_out("move_with_done", 1'b1, 64'd5, 64'h1A0, 1'b0, 1'b0);
    mv(UP);
    expect_out("done_hold", 1'b1, 64'd5, 64'h1A0, 1'b0, 1'b0);
    do_start();
    for (int i = 0; i < 7; i++) mv(LEFT);
    finish_seq();
    expect_out("done_cnt7", 1'b1, 64'd7, 64'h2AAA, 1'b0, 1'b0);
    start    = 1'b1;
    mv_valid = 1'b1;
    mv_dir   = RIGHT;
    cyc();
    start    = 1'b0;
    mv_valid = 1'b0;
    expect_out("start_wins", 1'b0, 64'd0, 64'h0, 1'b0, 1'b1);
    cyc();
    cyc();
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
      total += q.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
